// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer RAM between the VGA
// display fetch (fixed read slot per in-image pixel) and a camera writer
// whose requests are queued in a small FIFO and drained into every other
// cycle. The fetched pixel leaves with hsync/vsync/de delayed to match.
module vga_fb_arbiter #(
  parameter int   c_img_cols   = 160,
  parameter int   c_img_rows   = 120,
  parameter int   c_nb_addr    = 15,
  parameter int   c_nb_data    = 8,
  parameter int   c_fifo_depth = 4,
  parameter logic c_synch_act  = 1'b0
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 new_pxl,
  input  logic                 visible,
  input  logic [9:0]           col,
  input  logic [9:0]           row,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 cam_we,
  input  logic [c_nb_addr-1:0] cam_addr,
  input  logic [c_nb_data-1:0] cam_data,
  output logic                 cam_rdy,
  output logic [c_nb_addr-1:0] mem_addr,
  output logic                 mem_we,
  output logic [c_nb_data-1:0] mem_wdata,
  input  logic [c_nb_data-1:0] mem_rdata,
  output logic [c_nb_data-1:0] pxl_data,
  output logic                 pxl_de,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 ovf
);

  localparam int c_pw     = $clog2(c_fifo_depth);
  localparam int c_npix_i = c_img_cols * c_img_rows;

  localparam logic [9:0]           c_cols_w    = c_img_cols[9:0];
  localparam logic [9:0]           c_rows_w    = c_img_rows[9:0];
  localparam logic [c_nb_addr-1:0] c_line_step = c_img_cols[c_nb_addr-1:0];
  localparam logic [c_nb_addr:0]   c_npix      = c_npix_i[c_nb_addr:0];
  localparam logic [c_pw:0]        c_full      = c_fifo_depth[c_pw:0];
  localparam logic [c_pw:0]        c_cnt_one   = (c_pw+1)'(1);
  localparam logic [c_pw-1:0]      c_ptr_one   = c_pw'(1);

  logic                 in_img;
  logic                 rd_slot;
  logic                 wr_slot;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic [9:0]           row_q;
  logic [c_nb_addr-1:0] line_base;
  logic [c_nb_addr-1:0] line_base_cur;
  logic [c_nb_addr-1:0] rd_addr;
  logic [c_nb_addr-1:0] addr_q;
  logic [c_nb_data-1:0] wdata_q;

  logic [c_nb_addr-1:0] fifo_addr [c_fifo_depth];
  logic [c_nb_data-1:0] fifo_data [c_fifo_depth];
  logic [c_pw-1:0]      wr_ptr;
  logic [c_pw-1:0]      rd_ptr;
  logic [c_pw:0]        count;

  logic                 a_img;
  logic                 a_vis;
  logic                 a_hs;
  logic                 a_vs;

  assign in_img   = visible && (col < c_cols_w) && (row < c_rows_w);
  assign rd_slot  = !new_pxl && in_img;
  assign wr_slot  = !rd_slot;
  assign cam_rdy  = (count != c_full);
  assign in_range = ({1'b0, cam_addr} < c_npix);
  assign push     = cam_we && cam_rdy && in_range;
  assign pop      = wr_slot && (count != '0);
  assign rd_addr  = line_base_cur + c_nb_addr'(col);

  // Line base for the current row, advanced in the very first cycle of a new line
  always_comb begin
    line_base_cur = line_base;
    if (row == 10'd0)
      line_base_cur = '0;
    else if ((row != row_q) && (row < c_rows_w))
      line_base_cur = line_base + c_line_step;
  end

  // Remember the row and the line base so a row change is seen exactly once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q     <= '0;
      line_base <= '0;
    end else begin
      row_q     <= row;
      line_base <= line_base_cur;
    end
  end

  // RAM port mux: slot-A read wins, otherwise drain the FIFO head, otherwise hold
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (rd_slot) begin
      mem_addr = rd_addr;
    end else if (pop) begin
      mem_addr  = fifo_addr[rd_ptr];
      mem_we    = 1'b1;
      mem_wdata = fifo_data[rd_ptr];
    end
  end

  // Keep the last address/data driven so idle write slots leave the bus still
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // FIFO storage; contents need no reset since count guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cam_addr;
      fifo_data[wr_ptr] <= cam_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + c_ptr_one;
      if (pop)  rd_ptr <= rd_ptr + c_ptr_one;
      case ({push, pop})
        2'b10:   count <= count + c_cnt_one;
        2'b01:   count <= count - c_cnt_one;
        default: count <= count;
      endcase
      if (cam_we && !cam_rdy && in_range)
        ovf <= 1'b1;
    end
  end

  // Capture the slot-A context that has to travel alongside the read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_img <= 1'b0;
      a_vis <= 1'b0;
      a_hs  <= ~c_synch_act;
      a_vs  <= ~c_synch_act;
    end else if (!new_pxl) begin
      a_img <= in_img;
      a_vis <= visible;
      a_hs  <= hsync_in;
      a_vs  <= vsync_in;
    end
  end

  // Register the pixel and its sync/de at the end of slot B, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl_data  <= '0;
      pxl_de    <= 1'b0;
      hsync_out <= ~c_synch_act;
      vsync_out <= ~c_synch_act;
    end else if (new_pxl) begin
      pxl_data  <= a_img ? mem_rdata : '0;
      pxl_de    <= a_vis;
      hsync_out <= a_hs;
      vsync_out <= a_vs;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: drives a shortened VGA raster plus camera bursts and
// compares RAM traffic and the delayed pixel stream against queued expectations.
module tb_vga_fb_arbiter;

  localparam int COLS     = 160;
  localparam int ROWS     = 120;
  localparam int NA       = 15;
  localparam int ND       = 8;
  localparam int DEPTH    = 4;
  localparam int H_TOTAL  = 240;
  localparam int H_VIS    = 220;
  localparam int HS_START = 225;
  localparam int HS_END   = 230;
  localparam int V_VIS    = 480;
  localparam int VS_ROW   = 500;

  typedef struct packed {
    logic [NA-1:0] addr;
    logic [ND-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [ND-1:0] data;
    logic          de;
    logic          hs;
    logic          vs;
  } px_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          new_pxl;
  logic          visible;
  logic [9:0]    col;
  logic [9:0]    row;
  logic          hsync_in;
  logic          vsync_in;
  logic          cam_we;
  logic [NA-1:0] cam_addr;
  logic [ND-1:0] cam_data;
  logic          cam_rdy;
  logic [NA-1:0] mem_addr;
  logic          mem_we;
  logic [ND-1:0] mem_wdata;
  logic [ND-1:0] mem_rdata;
  logic [ND-1:0] pxl_data;
  logic          pxl_de;
  logic          hsync_out;
  logic          vsync_out;
  logic          ovf;

  logic [ND-1:0] ram     [2**NA];
  logic [ND-1:0] exp_ram [2**NA];
  logic          ram_ready = 1'b0;

  wr_t           wq[$];
  px_t           pq[$];
  logic          m_ovf;
  logic [NA-1:0] m_last_addr;
  int            burst_n;
  logic [NA-1:0] burst_addr;
  logic [ND-1:0] burst_data;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_addr(NA), .c_nb_data(ND),
    .c_fifo_depth(DEPTH), .c_synch_act(1'b0)
  ) dut (
    .rst(rst), .clk(clk), .new_pxl(new_pxl), .visible(visible), .col(col), .row(row),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cam_we(cam_we), .cam_addr(cam_addr),
    .cam_data(cam_data), .cam_rdy(cam_rdy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pxl_data(pxl_data), .pxl_de(pxl_de),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .ovf(ovf)
  );

  // Synchronous single-port RAM, preloaded with RAM[k] = k[7:0] on the first edge
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < 2**NA; k++) ram[k] <= k[ND-1:0];
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_mem_addr"},  mem_addr,  0);
    checkOutput({tag, "_mem_we"},    mem_we,    0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_pxl_data"},  pxl_data,  0);
    checkOutput({tag, "_pxl_de"},    pxl_de,    0);
    checkOutput({tag, "_hsync_out"}, hsync_out, 1);
    checkOutput({tag, "_vsync_out"}, vsync_out, 1);
    checkOutput({tag, "_ovf"},       ovf,       0);
    checkOutput({tag, "_cam_rdy"},   cam_rdy,   1);
  endtask

  task automatic applyStimulus(input int c, input int r, input logic b);
    col      = c[9:0];
    row      = r[9:0];
    new_pxl  = b;
    visible  = (c < H_VIS) && (r < V_VIS);
    hsync_in = (c >= HS_START && c < HS_END) ? 1'b0 : 1'b1;
    vsync_in = (r == VS_ROW) ? 1'b0 : 1'b1;
    if (burst_n > 0) begin
      cam_we     = 1'b1;
      cam_addr   = burst_addr;
      cam_data   = burst_data;
      burst_n--;
      burst_addr = burst_addr + 1'b1;
      burst_data = burst_data + 1'b1;
    end else begin
      cam_we = 1'b0;
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  task automatic evalCycle(input int c, input int r, input logic b);
    logic vis, img, rd, full;
    int   a;
    wr_t  w;
    px_t  p;
    vis  = (c < H_VIS) && (r < V_VIS);
    img  = vis && (c < COLS) && (r < ROWS);
    rd   = !b && img;
    full = (wq.size() == DEPTH);
    checkOutput("cam_rdy", cam_rdy, !full);
    checkOutput("ovf", ovf, m_ovf);
    if (rd) begin
      a = r * COLS + c;
      checkOutput("rd_addr", mem_addr, a);
      checkOutput("rd_we", mem_we, 0);
      m_last_addr = a[NA-1:0];
    end else if (wq.size() != 0) begin
      w = wq.pop_front();
      checkOutput("wr_we", mem_we, 1);
      checkOutput("wr_addr", mem_addr, w.addr);
      checkOutput("wr_data", mem_wdata, w.data);
      m_last_addr = w.addr;
    end else begin
      checkOutput("idle_we", mem_we, 0);
      checkOutput("idle_addr", mem_addr, m_last_addr);
    end
    if (!b) begin
      if (pq.size() != 0) begin
        p = pq.pop_front();
        checkOutput("pxl_data", pxl_data, p.data);
        checkOutput("pxl_de", pxl_de, p.de);
        checkOutput("hsync_out", hsync_out, p.hs);
        checkOutput("vsync_out", vsync_out, p.vs);
      end
      p.data = img ? exp_ram[r * COLS + c] : '0;
      p.de   = vis;
      p.hs   = (c >= HS_START && c < HS_END) ? 1'b0 : 1'b1;
      p.vs   = (r == VS_ROW) ? 1'b0 : 1'b1;
      pq.push_back(p);
    end
    if (cam_we && (int'(cam_addr) < COLS * ROWS)) begin
      if (!full) begin
        w.addr = cam_addr;
        w.data = cam_data;
        wq.push_back(w);
        exp_ram[cam_addr] = cam_data;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic runCycle(input int c, input int r, input logic b);
    applyStimulus(c, r, b);
    #2;
    evalCycle(c, r, b);
    @(posedge clk);
    #1;
  endtask

  // One raster line; optional camera burst starting at slot A of column bc,
  // optional early exit once the write queue holds stop_cnt entries
  task automatic runLine(input int r, input int bc, input int ba, input int bd,
                         input int bn, input int stop_cnt);
    for (int c = 0; c < H_TOTAL; c++) begin
      if (c == bc) begin
        burst_n    = bn;
        burst_addr = ba[NA-1:0];
        burst_data = bd[ND-1:0];
      end
      runCycle(c, r, 1'b0);
      if (stop_cnt >= 0 && wq.size() == stop_cnt) return;
      runCycle(c, r, 1'b1);
      if (stop_cnt >= 0 && wq.size() == stop_cnt) return;
    end
  endtask

  task automatic clearModel();
    wq.delete();
    pq.delete();
    m_ovf       = 1'b0;
    m_last_addr = '0;
    burst_n     = 0;
  endtask

  initial begin
    for (int k = 0; k < 2**NA; k++) exp_ram[k] = k[ND-1:0];
    clearModel();
    burst_addr = '0;
    burst_data = '0;
    rst        = 1'b1;
    new_pxl    = 1'b0;
    visible    = 1'b0;
    col        = '0;
    row        = '0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    cam_we     = 1'b0;
    cam_addr   = '0;
    cam_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("por");
    rst = 1'b0;

    // Frame 1: reads, out-of-range write, in-image burst, overflow burst, blanking
    runLine(0,   -1, 0,     0,     0,  -1);
    runLine(1,   30, 19200, 8'h55, 1,  -1);
    runLine(2,   20, 100,   8'hA0, 4,  -1);
    runLine(3,   10, 16000, 8'h00, 12, -1);
    runLine(500, -1, 0,     0,     0,  -1);
    runLine(501, -1, 0,     0,     0,  -1);

    // Frame 2: row 0 shows the camera data, then reset with three writes pending
    runLine(0,   -1, 0,     0,     0,  -1);
    runLine(1,   50, 17000, 8'h10, 8,  3);
    burst_n = 0;
    cam_we  = 1'b0;
    new_pxl = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkReset("mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();

    // Frame 3: a single write after reset must drain in the next write slot
    runLine(0,   0,  18000, 8'h77, 1,  -1);
    runLine(1,   -1, 0,     0,     0,  -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between the VGA display fetch and the camera pixel writer.
- Display fetch is driven by vga_sync timing (50 MHz clk, one pixel every 2 clk) and owns one fixed read slot per in-image pixel.
- Camera writes are buffered in a small FIFO and drained into all remaining cycles.
- Also outputs the fetched pixel with hsync/vsync delayed to stay aligned with it.

Parameters:
c_img_cols, 160, image width in pixels, shown at top-left of the visible area
c_img_rows, 120, image height in lines
c_nb_addr, 15, RAM address width; must satisfy c_img_cols*c_img_rows <= 2**c_nb_addr
c_nb_data, 8, pixel width (RGB332)
c_fifo_depth, 4, camera write FIFO entries, power of two, >= 2
c_synch_act, 0, active level of hsync/vsync

Ports:
rst  in  1  asynchronous reset, active-high
clk  in  1  50 MHz system clock
new_pxl  in  1  pixel strobe from vga_sync, high every second clk
visible  in  1  visible-area flag from vga_sync
col  in  10  pixel column from vga_sync
row  in  10  line from vga_sync
hsync_in  in  1  hsync from vga_sync
vsync_in  in  1  vsync from vga_sync
cam_we  in  1  camera write request
cam_addr  in  c_nb_addr  camera write address
cam_data  in  c_nb_data  camera write data
cam_rdy  out  1  FIFO not full; a write is accepted when cam_we && cam_rdy
mem_addr  out  c_nb_addr  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  c_nb_data  RAM write data
mem_rdata  in  c_nb_data  RAM read data, valid 1 clk after the read address
pxl_data  out  c_nb_data  pixel to the DAC/encoder
pxl_de  out  1  delayed visible
hsync_out  out  1  hsync delayed to align with pxl_data
vsync_out  out  1  vsync delayed to align with pxl_data
ovf  out  1  sticky camera overflow flag

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, pxl_data=0, pxl_de=0, hsync_out=vsync_out=~c_synch_act, ovf=0, FIFO empty, cam_rdy=1, line_base=0.
- in_img = visible && col<c_img_cols && row<c_img_rows.
- Read address is line_base+col. No multiplier.
  - line_base is set to 0 when row==0.
  - On each row change with 0<row<c_img_rows, line_base increases by c_img_cols.
- Slot A (cycle with new_pxl=0):
  - If in_img: read, with mem_addr=line_base+col and mem_we=0.
  - Otherwise A is a write slot.
- Slot B (cycle with new_pxl=1): always a write slot. mem_rdata carries slot-A read data.
- Write slot: if the FIFO is non-empty, pop the head and drive mem_addr/mem_wdata with its contents and mem_we=1 for that cycle. Otherwise mem_we=0 and mem_addr holds its last value.
- A read is never delayed or displaced by writes.
- Pixel pipeline, registered at the end of slot B only:
  - pxl_data <= in_img(A) ? mem_rdata : 0
  - pxl_de <= visible(A)
  - hsync_out <= hsync_in(A), vsync_out <= vsync_in(A)
  - Latency is exactly 2 clk from the slot-A sample. Outputs are held between updates.
- FIFO is first-word-first-out and stores {addr, data}.
  - Push: cam_we && cam_rdy && cam_addr<c_img_cols*c_img_rows.
  - In-range write while full: dropped, ovf<=1, ovf stays set until rst.
  - Out-of-range write: dropped silently, ovf unchanged.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - cam_rdy = (count != c_fifo_depth), derived from the registered count.
- Bandwidth: at least 1 write per 2 clk is guaranteed; all writes drain in horizontal/vertical blanking.
- Reset mid-operation flushes the FIFO. Pending writes are lost and mem_we goes low immediately (asynchronous).

Test Plan:
1. Reset check: assert rst mid-frame -> all outputs at reset values within the same cycle; cam_rdy=1; ovf=0.
2. Read alignment: preload RAM[k]=k[7:0] and run a frame.
   - At col=5,row=2 slot A -> mem_addr=325, mem_we=0; 2 clk later pxl_data=0x45, pxl_de=1.
   - At col=200,row=2 -> pxl_data=0, pxl_de=1.
   - At row=500 -> pxl_de=0, vsync_out follows vsync_in delayed by 2 clk.
3. Writes during image region: 4 back-to-back writes (addr 100..103, data 0xA0..0xA3) -> each written in a write slot within 8 clk, in order; every slot-A read still issued.
4. Overflow: 12 consecutive cam_we cycles inside the image region -> cam_rdy drops once count reaches 4; first rejected write sets ovf=1; only accepted writes appear on mem_we, in order; ovf held until rst.
5. Out-of-range: cam_addr=19200 accepted by handshake -> no mem_we, ovf stays 0.
6. Reset mid-burst: rst while FIFO holds 3 entries -> no further mem_we after release; cam_rdy=1; next single write lands at its address within 2 clk.
